fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Run controller for the basic processor's fetch path: accepts a Start/ProgSel request from the testbench, loads the selected program's base address into the program counter, and advances the PC each retired instruction. It resolves jump/branch redirects from the opcode, ALU flags and a jump-target lookup, and ends the run on a halt opcode, a fault or a watchdog expiry. It sits between the instruction ROM, the ALU flags and the datapath write enables. It replaces the free-running program counter.

## Interface
- PC_W, 10: program counter width; instruction ROM depth 2^PC_W.
- CNT_W, 16: cycle counter width.
- MAX_CYCLES, 16'hFFF0: watchdog limit; used only with the watchdog compiled in.

- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  run request, sampled in IDLE and DONE.
- ProgSel  in  2  program select: 0, 1, 2 valid; 3 is illegal.
- Instruction  in  9  ROM word at PC, combinational read.
- Zero  in  1  ALU result == 0.
- Greater  in  1  ALU greater-than flag.
- Stall  in  1  datapath busy; current instruction not retired.
- PC  out  PC_W  current fetch address.
- InstrValid  out  1  current instruction retires this cycle; gates datapath write enables.
- Busy  out  1  high in LOAD and RUN.
- Ack  out  1  high in DONE.
- Fault  out  1  run ended abnormally; valid while Ack is high.
- CycleCount  out  CNT_W  cycles spent in RUN for the current or last run.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Reset values: IDLE, PC=0, InstrValid=0, Busy=0, Ack=0, Fault=0, CycleCount=0.
- IDLE or DONE with Start=1:
  - ProgSel ≤ 2 → LOAD. Clear Fault and CycleCount.
  - ProgSel = 3 → DONE with Fault=1.
- LOAD, one cycle: PC ← kProgBase[ProgSel] (0x000, 0x100, 0x200). Next state RUN.
- RUN, CycleCount increments every cycle and saturates at all-ones. InstrValid = !Stall.
- Retire priority when InstrValid=1:
  1. Opcode Instruction[8:5] == kHALT → DONE, PC held.
  2. Redirect → PC ← branch target. Redirect occurs on kJ, on kBRE with Zero=1, or on kBRGT with Greater=1. The target is looked up from Instruction[4:0]. An unmapped index (kTgtInvalid) → DONE with Fault=1.
  3. Otherwise PC ← PC+1. If PC = 2^PC_W−1, do not wrap: go to DONE with Fault=1.
- Stall=1 in RUN: PC, branch and halt evaluation all frozen. Flags are ignored.
- Start in LOAD or RUN is ignored.
- DONE: Ack=1, PC and CycleCount held, InstrValid=0. Stays in DONE until a new Start.

## Timing
- PC, state and CycleCount are registered. InstrValid, Busy and Ack decode combinationally from state and Stall.
- Start to first InstrValid: 2 cycles (IDLE→LOAD→RUN).
- Taken branch: zero bubbles; the target instruction is in RUN the next cycle.
- Halt retire to Ack=1: 1 cycle.
- Reset mid-run: IDLE immediately (asynchronous), all outputs take their reset values, no Ack.
- Start and halt in the same cycle: halt wins. Start is only seen once in DONE.

## Configuration
- SEQ_WATCHDOG_EN defined: in RUN, when CycleCount == MAX_CYCLES → DONE with Fault=1. This takes priority over retire in that cycle.
- SEQ_WATCHDOG_EN undefined: no limit; CycleCount only saturates.

## Structure
- Package definitions holds:
  - Opcodes kJ, kBRE, kBRGT, and the new kHALT.
  - kProgBase[3].
  - kTgtInvalid.
  - The 32-entry jump-target constant array.
  - The state enum seq_state_t.
- Sub-module branch_lut: combinational. Maps the 5-bit index to a PC_W-bit target and a valid bit. It is shared with any future decoder.

## Test plan
- Reset, then Start with ProgSel=1 → LOAD, then PC=0x100 in RUN. Straight-line code to kHALT at 0x105 → Ack at cycle 8, CycleCount=6, Fault=0.
- kBRE to index 0 with Zero=0 → PC+1. Same instruction with Zero=1 → PC=target[0] the next cycle. Repeat for kBRGT with Greater.
- Stall held 3 cycles on a taken branch → PC frozen, InstrValid=0. The branch is taken only when Stall drops; CycleCount still advances by 3.
- Jump with an unmapped index, and separately ProgSel=3 → DONE, Ack=1, Fault=1.
- Assert Reset mid-RUN → PC=0 and state IDLE in the same cycle. Then restart with ProgSel=0 → PC=0x000.
- With SEQ_WATCHDOG_EN and MAX_CYCLES=20, run a tight jump-to-self loop → DONE at CycleCount=20, Fault=1.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the fetch sequencer and its branch-target lookup:
//   - opcodes that the sequencer decodes from Instruction[8:5]
//   - per-program base addresses and the 32-entry jump-target table
//   - the run-controller state enum
//   Table entries are TGT_W bits wide so the same table can serve any
//   PC_W up to TGT_W. kTgtInvalid marks an index with no mapped target.
package fetch_sequencer_pkg;

    localparam int TGT_W = 16;

    // Opcodes (Instruction[8:5]); everything else retires as straight-line code.
    localparam logic [3:0] kJ    = 4'hA;
    localparam logic [3:0] kBRE  = 4'hB;
    localparam logic [3:0] kBRGT = 4'hC;
    localparam logic [3:0] kHALT = 4'hF;

    localparam logic [TGT_W-1:0] kProgBase [3] = '{16'h0000, 16'h0100, 16'h0200};

    localparam logic [TGT_W-1:0] kTgtInvalid = 16'hFFFF;

    localparam logic [TGT_W-1:0] kJumpTgt [32] = '{
        16'h0040, 16'h00C0, 16'h0210, 16'h0103,
        16'h0180, 16'h03FF, 16'h0020, 16'h02A0,
        16'h0300, 16'h0310, 16'h0320, 16'h0330,
        16'h0340, 16'h0350, 16'h0360, 16'h0370,
        16'h0050, 16'h0060, 16'h0070, 16'h0080,
        16'h0090, 16'h00A0, 16'h00B0, 16'h00D0,
        kTgtInvalid, kTgtInvalid, kTgtInvalid, kTgtInvalid,
        kTgtInvalid, kTgtInvalid, kTgtInvalid, kTgtInvalid
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    // Base address for a program select; select 3 never reaches here
    // (it is rejected before LOAD), the default only keeps the case full.
    function automatic logic [TGT_W-1:0] prog_base(input logic [1:0] sel);
        case (sel)
            2'd0:    return kProgBase[0];
            2'd1:    return kProgBase[1];
            2'd2:    return kProgBase[2];
            default: return kProgBase[0];
        endcase
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles the run-request, instruction/flag inputs and status outputs of
//   the fetch sequencer.
//   master : drives start/prog_sel/instruction/zero/greater/stall
//   slave  : the sequencer; drives pc/instr_valid/busy/ack/fault/cycle_count
interface fetch_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       prog_sel;
    logic [8:0]       instruction;
    logic             zero;
    logic             greater;
    logic             stall;
    logic [PC_W-1:0]  pc;
    logic             instr_valid;
    logic             busy;
    logic             ack;
    logic             fault;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, prog_sel, instruction, zero, greater, stall,
        input  pc, instr_valid, busy, ack, fault, cycle_count
    );

    modport slave (
        input  start, prog_sel, instruction, zero, greater, stall,
        output pc, instr_valid, busy, ack, fault, cycle_count
    );
endinterface

// File: rtl/fetch_sequencer_branch_lut.sv
// branch_lut
//   Combinational jump-target lookup shared by the sequencer and any future
//   decoder.
//   i_idx    : 5-bit target index (Instruction[4:0])
//   o_target : PC_W-bit branch target
//   o_valid  : 0 when the index is unmapped
module branch_lut
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [4:0]      i_idx,
    output logic [PC_W-1:0] o_target,
    output logic            o_valid
);
    logic [TGT_W-1:0] w_entry;

    assign w_entry  = kJumpTgt[i_idx];
    assign o_valid  = (w_entry != kTgtInvalid);
    assign o_target = w_entry[PC_W-1:0];
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Run controller for the fetch path. A Start request loads the selected
//   program's base address, then the PC advances on every retired
//   instruction, following J/BRE/BRGT redirects through branch_lut. The run
//   ends on HALT, an unmapped target, running off the top of the ROM, or
//   (optionally) the watchdog.
//   Ports:
//     i_clk : clock, rising edge
//     i_rst : asynchronous active-high reset
//     bus   : fetch_sequencer_if.slave (request, instruction, flags, status)
//   Build option:
//     SEQ_WATCHDOG_EN : end the run with a fault once CycleCount reaches
//                       MAX_CYCLES; otherwise the counter only saturates.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int          PC_W       = 10,
    parameter int          CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 32'h0000_FFF0
) (
    input logic               i_clk,
    input logic               i_rst,
    fetch_sequencer_if.slave  bus
);
`ifdef SEQ_WATCHDOG_EN
    localparam bit WD_ENABLE = 1'b1;
`else
    localparam bit WD_ENABLE = 1'b0;
`endif

    seq_state_t       r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;
    logic [1:0]       r_prog_sel;

    logic [3:0]       w_opcode;
    logic             w_redirect;
    logic [PC_W-1:0]  w_target;
    logic             w_target_ok;
    logic             w_pc_last;
    logic             w_wd_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    branch_lut #(.PC_W(PC_W)) u_lut (
        .i_idx    (bus.instruction[4:0]),
        .o_target (w_target),
        .o_valid  (w_target_ok)
    );

    assign w_opcode   = bus.instruction[8:5];
    assign w_redirect = (w_opcode == kJ)
                      | ((w_opcode == kBRE)  & bus.zero)
                      | ((w_opcode == kBRGT) & bus.greater);
    assign w_pc_last  = &r_pc;
    assign w_wd_hit   = WD_ENABLE && (r_cnt == CNT_W'(MAX_CYCLES));
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_cnt      <= '0;
            r_fault    <= 1'b0;
            r_prog_sel <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (bus.prog_sel == 2'd3) begin
                            r_state <= S_DONE;
                            r_fault <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD;
                            r_fault    <= 1'b0;
                            r_cnt      <= '0;
                            r_prog_sel <= bus.prog_sel;
                        end
                    end
                end
                S_LOAD: begin
                    r_pc    <= PC_W'(prog_base(r_prog_sel));
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_wd_hit) begin
                        // Watchdog pre-empts retire and freezes the count at the limit.
                        r_state <= S_DONE;
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (!bus.stall) begin
                            if (w_opcode == kHALT) begin
                                r_state <= S_DONE;
                            end else if (w_redirect) begin
                                if (w_target_ok) begin
                                    r_pc <= w_target;
                                end else begin
                                    r_state <= S_DONE;
                                    r_fault <= 1'b1;
                                end
                            end else if (w_pc_last) begin
                                // Falling off the top of the ROM is a fault, not a wrap.
                                r_state <= S_DONE;
                                r_fault <= 1'b1;
                            end else begin
                                r_pc <= r_pc + PC_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.cycle_count = r_cnt;
    assign bus.fault       = r_fault;
    assign bus.instr_valid = (r_state == S_RUN) && !bus.stall;
    assign bus.busy        = (r_state == S_LOAD) || (r_state == S_RUN);
    assign bus.ack         = (r_state == S_DONE);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench: a ROM image is loaded into a local array and read
//   combinationally at the DUT's PC. Before each clock the expected
//   post-edge outputs are pushed to a scoreboard queue; after the edge they
//   are popped and compared field by field.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned TB_MAX = 20;
`else
    localparam int unsigned TB_MAX = 32'h0000_FFF0;
`endif

    // Jump targets the bench expects for the indices it uses.
    localparam logic [15:0] T0 = 16'h0040;
    localparam logic [15:0] T1 = 16'h00C0;
    localparam logic [15:0] T2 = 16'h0210;
    localparam logic [15:0] T4 = 16'h0180;
    localparam logic [15:0] T5 = 16'h03FF;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic        iv;
        logic        busy;
        logic        ack;
        logic        fault;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [8:0] rom [1024];
    exp_t exp_q [$];
    int n_assert = 0;
    int n_fail   = 0;

    fetch_sequencer_if #(.PC_W(10), .CNT_W(16)) bus ();

    fetch_sequencer #(.PC_W(10), .CNT_W(16), .MAX_CYCLES(TB_MAX)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.instruction = rom[bus.pc];

    task automatic chk(input string tag, input string field,
                       input logic [15:0] obs, input logic [15:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, req);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] pc, input logic iv,
                        input logic busy, input logic ack, input logic fault,
                        input logic [15:0] cnt);
        exp_t e;
        e.tag = tag; e.pc = pc; e.iv = iv; e.busy = busy;
        e.ack = ack; e.fault = fault; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = exp_q.pop_front();
        chk(e.tag, "pc",    16'(bus.pc),          e.pc);
        chk(e.tag, "iv",    16'(bus.instr_valid), 16'(e.iv));
        chk(e.tag, "busy",  16'(bus.busy),        16'(e.busy));
        chk(e.tag, "ack",   16'(bus.ack),         16'(e.ack));
        chk(e.tag, "fault", 16'(bus.fault),       16'(e.fault));
        chk(e.tag, "cnt",   bus.cycle_count,      e.cnt);
        $display("check %-10s pc=%03h iv=%0b busy=%0b ack=%0b fault=%0b cnt=%0d",
                 e.tag, bus.pc, bus.instr_valid, bus.busy, bus.ack, bus.fault,
                 bus.cycle_count);
    endtask

    // Expect the given outputs after the next rising edge.
    task automatic cyc(input string tag, input logic [15:0] pc, input logic iv,
                       input logic busy, input logic ack, input logic fault,
                       input logic [15:0] cnt);
        push(tag, pc, iv, busy, ack, fault, cnt);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    // Expect the given outputs right now (no clock edge).
    task automatic now_chk(input string tag, input logic [15:0] pc, input logic iv,
                           input logic busy, input logic ack, input logic fault,
                           input logic [15:0] cnt);
        push(tag, pc, iv, busy, ack, fault, cnt);
        pop_check();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        rom[10'h001] = {kHALT, 5'd0};
        rom[10'h105] = {kHALT, 5'd0};
        rom[10'h200] = {kBRE,  5'd0};
        rom[10'h201] = {kBRE,  5'd0};
        rom[10'h202] = {kJ,    5'd5};
        rom[10'h040] = {kBRGT, 5'd1};
        rom[10'h041] = {kBRGT, 5'd1};
        rom[10'h0C0] = {kJ,    5'd2};
        rom[10'h210] = {kJ,    5'd31};

        bus.start = 1'b0; bus.prog_sel = 2'd0;
        bus.zero = 1'b0; bus.greater = 1'b0; bus.stall = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        now_chk("reset", 16'h000, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line program 1, HALT at 0x105
        bus.start = 1'b1; bus.prog_sel = 2'd1;
        cyc("t1_load", 16'h000, 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        cyc("t1_run", 16'h100, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cyc("t1_step", 16'h100 + 16'(i), 1, 1, 0, 0, 16'(i));
        cyc("t1_halt", 16'h105, 0, 0, 1, 0, 6);

        // Illegal program select
        bus.start = 1'b1; bus.prog_sel = 2'd3;
        cyc("sel3", 16'h105, 0, 0, 1, 1, 6);

        // Branches, stall, unmapped target
        bus.prog_sel = 2'd2;
        cyc("t2_load", 16'h105, 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        cyc("t2_run", 16'h200, 1, 1, 0, 0, 0);
        cyc("bre_nt", 16'h201, 1, 1, 0, 0, 1);
        bus.zero = 1'b1;
        cyc("bre_t", T0, 1, 1, 0, 0, 2);
        bus.zero = 1'b0;
        cyc("brgt_nt", T0 + 16'h1, 1, 1, 0, 0, 3);
        bus.greater = 1'b1;
        cyc("brgt_t", T1, 1, 1, 0, 0, 4);
        bus.greater = 1'b0;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("stall", T1, 0, 1, 0, 0, 16'(5 + i));
        bus.stall = 1'b0;
        cyc("j_after", T2, 1, 1, 0, 0, 8);
        cyc("j_unmap", T2, 0, 0, 1, 1, 9);

        // Reset mid-run, then restart program 0
        bus.start = 1'b1; bus.prog_sel = 2'd1;
        cyc("t4_load", T2, 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        cyc("t4_run", 16'h100, 1, 1, 0, 0, 0);
        cyc("t4_step", 16'h101, 1, 1, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        now_chk("mid_rst", 16'h000, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1; bus.prog_sel = 2'd0;
        cyc("p0_load", 16'h000, 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        cyc("p0_run", 16'h000, 1, 1, 0, 0, 0);
        cyc("p0_step", 16'h001, 1, 1, 0, 0, 1);
        cyc("p0_halt", 16'h001, 0, 0, 1, 0, 2);

        // PC at top of ROM: no wrap, fault
        bus.start = 1'b1; bus.prog_sel = 2'd2;
        cyc("t5_load", 16'h001, 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        cyc("t5_run", 16'h200, 1, 1, 0, 0, 0);
        cyc("t5_s1", 16'h201, 1, 1, 0, 0, 1);
        cyc("t5_s2", 16'h202, 1, 1, 0, 0, 2);
        cyc("t5_top", T5, 1, 1, 0, 0, 3);
        cyc("t5_wrap", T5, 0, 0, 1, 1, 4);

        // Start held throughout: ignored in LOAD/RUN, halt wins, then restart
        bus.start = 1'b1; bus.prog_sel = 2'd1;
        cyc("t6_load", T5, 0, 1, 0, 0, 0);
        for (int i = 0; i <= 5; i++) cyc("t6_run", 16'h100 + 16'(i), 1, 1, 0, 0, 16'(i));
        cyc("t6_halt", 16'h105, 0, 0, 1, 0, 6);
        cyc("t6_reld", 16'h105, 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        cyc("t6_run2", 16'h100, 1, 1, 0, 0, 0);

        // Jump-to-self loop
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rom[10'h100] = {kJ, 5'd4};
        rom[10'h180] = {kJ, 5'd4};
        bus.start = 1'b1; bus.prog_sel = 2'd1;
        cyc("t7_load", 16'h000, 0, 1, 0, 0, 0);
        bus.start = 1'b0;
        cyc("t7_run", 16'h100, 1, 1, 0, 0, 0);
`ifdef SEQ_WATCHDOG_EN
        for (int i = 1; i <= 20; i++) cyc("wd_loop", T4, 1, 1, 0, 0, 16'(i));
        cyc("wd_done", T4, 0, 0, 1, 1, 20);
`else
        for (int i = 1; i <= 25; i++) cyc("loop", T4, 1, 1, 0, 0, 16'(i));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
